// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU sequencer slice.
// Holds the op-code and FSM state enums used by alu_core and alu_sequencer.
package alu_pkg;

    localparam int DATA_W    = 8;
    localparam int CNT_W     = 16;
    localparam int OVF_CNT_W = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_if.sv
// Command and result valid/ready bundle between a stimulus source and the
// ALU sequencer. master = command issuer / result consumer, slave = sequencer.
interface alu_if #(
    parameter int NUM_BITS = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [NUM_BITS-1:0] cmd_a;
    logic [NUM_BITS-1:0] cmd_b;
    logic [1:0]          cmd_op;
    logic                res_valid;
    logic                res_ready;
    logic [NUM_BITS-1:0] res_data;
    logic                res_ovf;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: (a, b, op) -> (r, ovf) with signed add/sub overflow.
// Ports: a, b operands; op alu_op_t; r result; ovf signed overflow.
// Build option ALU_SAT_EN: overflowing ADD/SUB results clamp to max/min.
module alu_core
    import alu_pkg::*;
#(
    parameter int NUM_BITS = DATA_W
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  alu_op_t             op,
    output logic [NUM_BITS-1:0] r,
    output logic                ovf
);
    localparam int MSB = NUM_BITS - 1;

    logic [NUM_BITS-1:0] sum;
    logic [NUM_BITS-1:0] diff;
    logic [NUM_BITS-1:0] sat;
    logic                add_ovf;
    logic                sub_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

    // Clamp direction follows the sign of A: overflow only ever pushes
    // the result across the boundary on A's side.
    assign sat = a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};

    always_comb begin
        r   = '0;
        ovf = 1'b0;
        unique case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin
                r   = sum;
                ovf = add_ovf;
            end
            OP_SUB: begin
                r   = diff;
                ovf = sub_ovf;
            end
            default: begin
                r   = '0;
                ovf = 1'b0;
            end
        endcase
`ifdef ALU_SAT_EN
        if (ovf) begin
            r = sat;
        end
`endif
    end

`ifndef ALU_SAT_EN
    logic unused_sat;
    assign unused_sat = ^sat;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready front-end for alu_core: IDLE -> EXEC -> DONE per command.
// Ports: clk, rst_n (async low), bus (alu_if.slave), cnt_clr,
// op_count (wrapping), ovf_count (saturating). Option: ALU_SAT_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_BITS     = DATA_W,
    parameter int CNT_BITS     = CNT_W,
    parameter int OVF_CNT_BITS = OVF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_if.slave                    bus,
    input  logic                    cnt_clr,
    output logic [CNT_BITS-1:0]     op_count,
    output logic [OVF_CNT_BITS-1:0] ovf_count
);
    seq_state_t state;
    seq_state_t state_d;

    logic [NUM_BITS-1:0] a_q;
    logic [NUM_BITS-1:0] b_q;
    alu_op_t             op_q;

    logic [NUM_BITS-1:0] alu_r;
    logic                alu_ovf;

    logic [NUM_BITS-1:0] res_data_q;
    logic                res_ovf_q;

    logic cmd_ready;
    logic res_valid;
    logic load;
    logic exec;

    alu_core #(
        .NUM_BITS(NUM_BITS)
    ) u_core (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .r  (alu_r),
        .ovf(alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        load      = 1'b0;
        exec      = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    load    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_AND;
        end else if (load) begin
            a_q  <= bus.cmd_a;
            b_q  <= bus.cmd_b;
            op_q <= alu_op_t'(bus.cmd_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
        end else if (exec) begin
            res_data_q <= alu_r;
            res_ovf_q  <= alu_ovf;
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (cnt_clr) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (exec) begin
            op_count <= op_count + CNT_BITS'(1);
            if (alu_ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + OVF_CNT_BITS'(1);
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data_q;
    assign bus.res_ovf   = res_ovf_q;

endmodule
